// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; latches Execute bus, holds SRAM load data across stalls, aligns/extends loads.
module mem_stage #(
  parameter int EM_BUS_W = 195,
  parameter int MW_BUS_W = 191,
  parameter int MD_FOR_W = 38
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                W_allowin,
  output logic                M_allowin,
  input  logic                EM_valid,
  input  logic [EM_BUS_W-1:0] em_bus,
  input  logic [31:0]         data_sram_rdata,
  output logic                MW_valid,
  output logic [MW_BUS_W-1:0] mw_bus,
  output logic [MD_FOR_W-1:0] md_for_bus,
  output logic                M_ex
);
  logic                m_valid;
  logic                ready_go;
  logic [EM_BUS_W-1:0] em_r;
  logic                rbuf_valid;
  logic [31:0]         rbuf;
  logic [31:0]         pc;
  logic [31:0]         rf_wdata;
  logic                gr_we;
  logic [4:0]          dest;
  logic [3:0]          res;
  logic [31:0]         addr;
  logic                ex;
  logic [7:0]          ecode;
  logic                esubcode;
  logic [13:0]         csr_addr;
  logic                csr_we;
  logic [31:0]         csr_wmask;
  logic [31:0]         csr_wdata;
  logic                is_load;
  logic                capture;
  logic [31:0]         raw;
  logic [15:0]         half;
  logic [7:0]          byte_d;
  logic [31:0]         load_data;
  logic [31:0]         final_wdata;
  logic [31:0]         badv;
  assign {pc, rf_wdata, gr_we, dest, res, addr, ex, ecode, esubcode,
          csr_addr, csr_we, csr_wmask, csr_wdata} = em_r;
  assign ready_go  = 1'b1;
  assign M_allowin = !m_valid | (W_allowin & ready_go);
  assign MW_valid  = m_valid & !flush;
  assign is_load   = m_valid & |res;
  // rbuf is only captured on the first stalled cycle; afterwards the SRAM port no longer holds our word
  assign capture   = is_load & !W_allowin & !rbuf_valid & !flush;
  assign raw       = rbuf_valid ? rbuf : data_sram_rdata;
  assign half      = raw[{addr[1], 4'b0} +: 16];
  assign byte_d    = raw[{addr[1:0], 3'b0} +: 8];
  always_comb begin
    load_data   = res[3] ? raw
                : res[1] ? {{16{!res[2] & half[15]}}, half}
                : res[0] ? {{24{!res[2] & byte_d[7]}}, byte_d}
                : raw;
    final_wdata = (|res & !ex) ? load_data : rf_wdata;
    badv        = (ecode == 8'h08) ? addr : 32'h0;
  end
  assign mw_bus     = {pc, final_wdata, gr_we & !ex, dest, ex, ecode, esubcode,
                       csr_addr, csr_we, csr_wmask, csr_wdata, badv};
  assign md_for_bus = {is_load & !ex, dest & {5{m_valid & gr_we & !ex}}, final_wdata};
  assign M_ex       = m_valid & ex;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      em_r       <= '0;
      rbuf_valid <= 1'b0;
      rbuf       <= '0;
    end else begin
      m_valid    <= flush ? 1'b0 : M_allowin ? EM_valid : m_valid;
      if (EM_valid & M_allowin & !flush) em_r <= em_bus;
      rbuf_valid <= (flush | (W_allowin & m_valid)) ? 1'b0 : capture ? 1'b1 : rbuf_valid;
      if (capture) rbuf <= data_sram_rdata;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         W_allowin = 1'b1;
  logic         M_allowin;
  logic         EM_valid = 1'b0;
  logic [194:0] em_bus = '0;
  logic [31:0]  data_sram_rdata = '0;
  logic         MW_valid;
  logic [190:0] mw_bus;
  logic [37:0]  md_for_bus;
  logic         M_ex;
  int           checks = 0;
  int           errors = 0;
  mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .W_allowin(W_allowin), .M_allowin(M_allowin),
    .EM_valid(EM_valid), .em_bus(em_bus), .data_sram_rdata(data_sram_rdata),
    .MW_valid(MW_valid), .mw_bus(mw_bus), .md_for_bus(md_for_bus), .M_ex(M_ex)
  );
  always #5 clk = ~clk;
  function automatic logic [194:0] mk(input logic [31:0] wd, input logic we, input logic [4:0] dst,
                                      input logic [3:0] res, input logic [31:0] addr,
                                      input logic ex, input logic [7:0] ec);
    return {32'h1c00_0000, wd, we, dst, res, addr, ex, ec, 1'b0, 14'h0, 1'b0, 32'h0, 32'h0};
  endfunction
  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    check("rst_mw_valid", 38'(MW_valid), 38'd0);
    check("rst_m_ex", 38'(M_ex), 38'd0);
    check("rst_md_for", md_for_bus, 38'd0);
    check("rst_allowin", 38'(M_allowin), 38'd1);
    step();
    rst = 1'b0;
    // ld.b signed
    EM_valid = 1'b1; W_allowin = 1'b1;
    em_bus = mk(32'h0, 1'b1, 5'd4, 4'b0001, 32'h1003, 1'b0, 8'h0);
    step();
    EM_valid = 1'b0; data_sram_rdata = 32'h80FF_1234;
    #1;
    check("ldb_valid", 38'(MW_valid), 38'd1);
    check("ldb_wdata", 38'(mw_bus[158:127]), 38'hFFFF_FF80);
    check("ldb_md_for", md_for_bus, {1'b1, 5'd4, 32'hFFFF_FF80});
    step();
    check("ldb_one_cycle", 38'(MW_valid), 38'd0);
    // ld.hu then ld.h
    EM_valid = 1'b1; em_bus = mk(32'h0, 1'b1, 5'd5, 4'b0110, 32'h1002, 1'b0, 8'h0);
    step();
    em_bus = mk(32'h0, 1'b1, 5'd6, 4'b0010, 32'h1002, 1'b0, 8'h0);
    data_sram_rdata = 32'h8001_0000;
    #1;
    check("ldhu_wdata", 38'(mw_bus[158:127]), 38'h0000_8001);
    step();
    EM_valid = 1'b0;
    #1;
    check("ldh_wdata", 38'(mw_bus[158:127]), 38'hFFFF_8001);
    step();
    // ld.w held across back-pressure
    EM_valid = 1'b1; W_allowin = 1'b0;
    em_bus = mk(32'h0, 1'b1, 5'd7, 4'b1000, 32'h2000, 1'b0, 8'h0);
    step();
    EM_valid = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    check("ldw_c1_wdata", 38'(mw_bus[158:127]), 38'hDEAD_BEEF);
    check("ldw_c1_allowin", 38'(M_allowin), 38'd0);
    for (int i = 2; i <= 3; i++) begin
      step();
      data_sram_rdata = 32'h1234_5678 + 32'(i);
      #1;
      check($sformatf("ldw_c%0d_wdata", i), 38'(mw_bus[158:127]), 38'hDEAD_BEEF);
      check($sformatf("ldw_c%0d_allowin", i), 38'(M_allowin), 38'd0);
    end
    W_allowin = 1'b1;
    #1;
    check("ldw_rel_valid", 38'(MW_valid), 38'd1);
    check("ldw_rel_wdata", 38'(mw_bus[158:127]), 38'hDEAD_BEEF);
    step();
    check("ldw_left", 38'(MW_valid), 38'd0);
    // exception: ADEM
    EM_valid = 1'b1;
    em_bus = mk(32'h0000_0055, 1'b1, 5'd9, 4'b0010, 32'h1001, 1'b1, 8'h08);
    step();
    EM_valid = 1'b0;
    #1;
    check("ex_m_ex", 38'(M_ex), 38'd1);
    check("ex_gr_we", 38'(mw_bus[126]), 38'd0);
    check("ex_badv", 38'(mw_bus[31:0]), 38'h1001);
    check("ex_ecode", 38'(mw_bus[119:112]), 38'h08);
    check("ex_md_for", md_for_bus, {1'b0, 5'd0, 32'h0000_0055});
    step();
    check("ex_clear", 38'(M_ex), 38'd0);
    // flush with rbuf_valid set
    EM_valid = 1'b1; W_allowin = 1'b0;
    em_bus = mk(32'h0, 1'b1, 5'd3, 4'b1000, 32'h3000, 1'b0, 8'h0);
    step();
    EM_valid = 1'b0; data_sram_rdata = 32'hAAAA_5555;
    step();
    data_sram_rdata = 32'h0; flush = 1'b1;
    #1;
    check("flush_mw_valid", 38'(MW_valid), 38'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_after_valid", 38'(MW_valid), 38'd0);
    check("flush_after_allowin", 38'(M_allowin), 38'd1);
    W_allowin = 1'b1; EM_valid = 1'b1;
    em_bus = mk(32'h0, 1'b1, 5'd3, 4'b1000, 32'h3004, 1'b0, 8'h0);
    step();
    EM_valid = 1'b0; data_sram_rdata = 32'h1357_9BDF;
    #1;
    check("flush_rbuf_cleared", 38'(mw_bus[158:127]), 38'h1357_9BDF);
    step();
    // leave and new entry in the same cycle
    EM_valid = 1'b1; W_allowin = 1'b0;
    em_bus = mk(32'h0, 1'b1, 5'd1, 4'b1000, 32'h4000, 1'b0, 8'h0);
    step();
    EM_valid = 1'b0; data_sram_rdata = 32'h1111_1111;
    step();
    data_sram_rdata = 32'h9999_9999;
    W_allowin = 1'b1; EM_valid = 1'b1;
    em_bus = mk(32'h0, 1'b1, 5'd2, 4'b1000, 32'h4004, 1'b0, 8'h0);
    #1;
    check("swap_old_wdata", 38'(mw_bus[158:127]), 38'h1111_1111);
    step();
    EM_valid = 1'b0; data_sram_rdata = 32'h2222_2222;
    #1;
    check("swap_new_wdata", 38'(mw_bus[158:127]), 38'h2222_2222);
    step();
    // async reset during back-to-back loads
    EM_valid = 1'b1;
    em_bus = mk(32'h0, 1'b1, 5'd8, 4'b1000, 32'h5000, 1'b1, 8'h0);
    step();
    data_sram_rdata = 32'h0BAD_F00D;
    #1;
    check("pre_rst_m_ex", 38'(M_ex), 38'd1);
    rst = 1'b1;
    #1;
    check("async_rst_mw_valid", 38'(MW_valid), 38'd0);
    check("async_rst_m_ex", 38'(M_ex), 38'd0);
    check("async_rst_md_for", md_for_bus, 38'd0);
    EM_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", 38'(MW_valid), 38'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
